sha256_avalon_padder: RTL and testbench

- Avalon-MM slave that accepts a SHA-256 message as 32-bit big-endian words plus a final partial word.
- Performs the FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit-length).
- Emits complete 512-bit blocks through a parametrised block FIFO with a valid/ready handshake to the SHA-256 compression core inside soc_system.
- Lets the HPS stream arbitrary-length messages without doing software padding.

---
 rtl/sha256_avalon_padder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sha256_avalon_padder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_avalon_padder.sv
// Avalon-MM sink that applies SHA-256 message padding and streams finished
// 512-bit blocks to the compression core through a small block FIFO.
module sha256_avalon_padder #(
  parameter int unsigned BLOCK_FIFO_DEPTH = 2,
  parameter int unsigned CNT_W            = 4
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  input  logic [1:0]   avs_address,
  input  logic         avs_write,
  input  logic [31:0]  avs_writedata,
  input  logic         avs_read,
  output logic [31:0]  avs_readdata,
  output logic         avs_waitrequest,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         blk_valid,
  input  logic         blk_ready
);

  localparam int unsigned PTR_W = (BLOCK_FIFO_DEPTH > 1) ? $clog2(BLOCK_FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BLOCK_FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BLOCK_FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StPad, StZero, StLenH, StLenL, StPush} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q [16];
  logic [3:0]  idx_q, idx_d;
  logic [63:0] len_q, len_d;
  logic [31:0] tail_q, tail_d;
  logic [1:0]  nb_q, nb_d;
  logic        acc_full_q, acc_full_d;
  logic        first_q, first_d;
  logic [31:0] readdata_d;

  logic         acc_we;
  logic [3:0]   acc_widx;
  logic [31:0]  acc_wdata;
  logic         push_req, push_last, push_ok, push_fire, pop, soft_clr, wr_ok, busy;
  logic [511:0] push_data;
  logic [31:0]  tail_mask, pad_word;

  logic [511:0]     fifo_data  [BLOCK_FIFO_DEPTH];
  logic             fifo_first [BLOCK_FIFO_DEPTH];
  logic             fifo_last  [BLOCK_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign busy      = (state_q != StIdle) || acc_full_q;
  assign fifo_full = (count_q == DEPTH_CNT);
  assign blk_valid = (count_q != '0);
  assign pop       = blk_valid && blk_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = !fifo_full || pop;
  assign push_fire = push_req && push_ok;
  assign wr_ok     = avs_write && !avs_waitrequest;

  assign blk_data  = blk_valid ? fifo_data[rd_ptr_q]  : '0;
  assign blk_first = blk_valid && fifo_first[rd_ptr_q];
  assign blk_last  = blk_valid && fifo_last[rd_ptr_q];

  // Keep the top nb tail bytes, then place the 0x80 marker right after them.
  assign tail_mask = ~(32'hFFFF_FFFF >> {nb_q, 3'b000});
  assign pad_word  = (tail_q & tail_mask) | (32'h80 << (5'd24 - {nb_q, 3'b000}));

  always_comb begin
    avs_waitrequest = 1'b0;
    if (avs_write) begin
      if (state_q != StIdle) begin
        avs_waitrequest = 1'b1;
      end else if ((avs_address == 2'd0 || avs_address == 2'd3) && acc_full_q) begin
        avs_waitrequest = 1'b1;
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    if (avs_read) begin
      unique case (avs_address)
        2'd0: readdata_d = {16'b0, 8'(count_q), 6'b0, fifo_full, busy};
        2'd1: readdata_d = '0;
        2'd2: readdata_d = len_q[31:0];
        2'd3: readdata_d = len_q[63:32];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    tail_d     = tail_q;
    nb_d       = nb_q;
    acc_full_d = acc_full_q;
    first_d    = first_q;
    acc_we     = 1'b0;
    acc_widx   = idx_q;
    acc_wdata  = '0;
    push_req   = 1'b0;
    push_last  = 1'b0;
    soft_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc_full_q) begin
          push_req = 1'b1;
          if (push_ok) acc_full_d = 1'b0;
        end
        if (wr_ok) begin
          unique case (avs_address)
            2'd0: begin
              acc_we    = 1'b1;
              acc_wdata = avs_writedata;
              idx_d     = idx_q + 4'd1;
              len_d     = len_q + 64'd4;
              if (idx_q == 4'd15) begin
                push_req = 1'b1;
                if (!push_ok) acc_full_d = 1'b1;
              end
            end
            2'd1: soft_clr = avs_writedata[0];
            2'd2: tail_d = avs_writedata;
            2'd3: begin
              nb_d    = avs_writedata[1:0];
              len_d   = len_q + {62'b0, avs_writedata[1:0]};
              state_d = StPad;
            end
          endcase
        end
      end
      StPad: begin
        acc_wdata = pad_word;
        if (idx_q == 4'd15) begin
          push_req = 1'b1;
          if (push_ok) begin
            acc_we  = 1'b1;
            idx_d   = 4'd0;
            state_d = StZero;
          end
        end else begin
          acc_we  = 1'b1;
          idx_d   = idx_q + 4'd1;
          state_d = StZero;
        end
      end
      StZero: begin
        if (idx_q == 4'd14) begin
          state_d = StLenH;
        end else if (idx_q == 4'd15) begin
          push_req = 1'b1;
          if (push_ok) begin
            acc_we = 1'b1;
            idx_d  = 4'd0;
          end
        end else begin
          acc_we = 1'b1;
          idx_d  = idx_q + 4'd1;
        end
      end
      StLenH: begin
        acc_we    = 1'b1;
        acc_wdata = len_q[60:29];
        idx_d     = 4'd15;
        state_d   = StLenL;
      end
      StLenL: begin
        acc_we    = 1'b1;
        acc_wdata = {len_q[28:0], 3'b000};
        state_d   = StPush;
      end
      StPush: begin
        push_req  = 1'b1;
        push_last = 1'b1;
        if (push_ok) begin
          idx_d   = 4'd0;
          len_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (push_fire) first_d = push_last;
  end

  // The pushed block includes any word being written into the accumulator this cycle.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < 16; i++) begin
      push_data[511 - 32*i -: 32] = (acc_we && acc_widx == 4'(i)) ? acc_wdata : acc_q[i];
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= StIdle;
      acc_q        <= '{default: '0};
      idx_q        <= '0;
      len_q        <= '0;
      tail_q       <= '0;
      nb_q         <= '0;
      acc_full_q   <= 1'b0;
      first_q      <= 1'b1;
      avs_readdata <= '0;
    end else if (soft_clr) begin
      state_q      <= StIdle;
      acc_q        <= '{default: '0};
      idx_q        <= '0;
      len_q        <= '0;
      tail_q       <= '0;
      nb_q         <= '0;
      acc_full_q   <= 1'b0;
      first_q      <= 1'b1;
      avs_readdata <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      tail_q       <= tail_d;
      nb_q         <= nb_d;
      acc_full_q   <= acc_full_d;
      first_q      <= first_d;
      avs_readdata <= readdata_d;
      if (acc_we) acc_q[acc_widx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      fifo_data  <= '{default: '0};
      fifo_first <= '{default: 1'b0};
      fifo_last  <= '{default: 1'b0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (soft_clr) begin
      fifo_data  <= '{default: '0};
      fifo_first <= '{default: 1'b0};
      fifo_last  <= '{default: 1'b0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_fire) begin
        fifo_data[wr_ptr_q]  <= push_data;
        fifo_first[wr_ptr_q] <= first_q;
        fifo_last[wr_ptr_q]  <= push_last;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (push_fire && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push_fire && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_avalon_padder.sv
// Bench for sha256_avalon_padder: drives messages over Avalon-MM and compares
// emitted blocks with a byte-level FIPS 180-4 padding model.
module tb_sha256_avalon_padder;

  logic         clk_clk = 1'b0;
  logic         reset_reset = 1'b1;
  logic [1:0]   avs_address = '0;
  logic         avs_write = 1'b0;
  logic [31:0]  avs_writedata = '0;
  logic         avs_read = 1'b0;
  logic [31:0]  avs_readdata;
  logic         avs_waitrequest;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready = 1'b0;

  sha256_avalon_padder #(
    .BLOCK_FIFO_DEPTH(2),
    .CNT_W           (4)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .blk_data       (blk_data),
    .blk_first      (blk_first),
    .blk_last       (blk_last),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  blk_t exp_q[$];
  blk_t got_q[$];
  blk_t last_got;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;
  logic ready_force = 1'b0;

  always @(negedge clk_clk) blk_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;

  // Record every handshake; the pop happens on the following rising edge.
  always begin
    blk_t b;
    @(negedge clk_clk);
    #2;
    if (!reset_reset && blk_valid && blk_ready) begin
      b.data  = blk_data;
      b.first = blk_first;
      b.last  = blk_last;
      got_q.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_msg(input byte unsigned msg[$]);
    byte unsigned    p[$];
    longint unsigned bits;
    blk_t            b;
    int              nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int k = 0; k < nblk; k++) begin
      b.data = '0;
      for (int j = 0; j < 64; j++) b.data[511 - 8*j -: 8] = p[64*k + j];
      b.first = (k == 0);
      b.last  = (k == nblk - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data, output int waits);
    logic stall;
    waits = 0;
    @(negedge clk_clk);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    #1 stall = avs_waitrequest;
    forever begin
      @(posedge clk_clk);
      if (!stall) break;
      waits++;
      if (waits > 4000) begin
        check("write_timeout", 32'(waits), 32'd0);
        break;
      end
      #1 stall = avs_waitrequest;
    end
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    int w;
    bus_write(addr, data, w);
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk_clk);
    avs_address = addr;
    avs_read    = 1'b1;
    @(posedge clk_clk);
    #1;
    avs_read = 1'b0;
    data     = avs_readdata;
  endtask

  // Sends full words, then a tail with junk in its unused low bytes, then FINISH.
  task automatic send_msg(input byte unsigned msg[$]);
    int          nfull;
    int          nb;
    logic [31:0] tail;
    nfull = msg.size() / 4;
    nb    = msg.size() % 4;
    for (int i = 0; i < nfull; i++) begin
      wr(2'd0, {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
    end
    if (nb != 0) begin
      tail = $urandom;
      for (int k = 0; k < nb; k++) tail[31 - 8*k -: 8] = msg[4*nfull + k];
      wr(2'd2, tail);
    end
    wr(2'd3, 32'(nb));
    model_msg(msg);
  endtask

  task automatic drain_check(input string tag);
    int   cyc;
    blk_t g;
    blk_t e;
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 5000) begin
      @(negedge clk_clk);
      cyc++;
    end
    repeat (40) @(negedge clk_clk);
    check({tag, "_count"}, 512'(got_q.size()), 512'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      last_got = g;
      check({tag, "_data"}, g.data, e.data);
      check({tag, "_first"}, 512'(g.first), 512'(e.first));
      check({tag, "_last"}, 512'(g.last), 512'(e.last));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    byte unsigned msg[$];
    byte unsigned abc[$];
    logic [31:0]  rd;
    logic [31:0]  w32;
    int           waits;
    int           wmax;
    int           len;

    abc = '{8'h61, 8'h62, 8'h63};

    // Reset state
    #1;
    check("rst_valid", 512'(blk_valid), 512'(0));
    check("rst_readdata", 512'(avs_readdata), 512'(0));
    check("rst_waitreq", 512'(avs_waitrequest), 512'(0));
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    bus_read(2'd0, rd);
    check("rst_status", 512'(rd), 512'(0));
    bus_read(2'd2, rd);
    check("rst_len", 512'(rd), 512'(0));

    // "abc" with the block held back so the length can be read first
    ready_force = 1'b0;
    send_msg(abc);
    bus_read(2'd2, rd);
    check("abc_len", 512'(rd), 512'(3));
    ready_force = 1'b1;
    drain_check("abc");
    check("abc_w0", 512'(last_got.data[511:480]), 512'(32'h6162_6380));
    check("abc_w15", 512'(last_got.data[31:0]), 512'(32'h0000_0018));
    bus_read(2'd2, rd);
    check("abc_len_after", 512'(rd), 512'(0));

    // Empty message
    msg.delete();
    send_msg(msg);
    drain_check("empty");
    check("empty_w0", 512'(last_got.data[511:480]), 512'(32'h8000_0000));

    // 56 bytes: marker lands in slot 14 and length spills into a second block
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'h01);
    send_msg(msg);
    drain_check("w14");
    check("w14_len", 512'(last_got.data[31:0]), 512'(32'h0000_01C0));

    // Backpressure with a same-cycle push and pop when the FIFO is full
    ready_force = 1'b0;
    repeat (2) @(negedge clk_clk);
    msg.delete();
    wmax = 0;
    for (int i = 0; i < 48; i++) begin
      w32 = $urandom;
      for (int k = 3; k >= 0; k--) msg.push_back(w32[8*k +: 8]);
      bus_write(2'd0, w32, waits);
      if (waits > wmax) wmax = waits;
    end
    check("bp_nowait", 512'(wmax), 512'(0));
    bus_read(2'd0, rd);
    check("bp_status_full", 512'(rd), 512'(32'h0000_0203));
    w32 = $urandom;
    for (int k = 3; k >= 0; k--) msg.push_back(w32[8*k +: 8]);
    fork
      bus_write(2'd0, w32, waits);
      begin
        repeat (10) @(posedge clk_clk);
        #1 ready_force = 1'b1;
        @(posedge clk_clk);
        #1 ready_force = 1'b0;
      end
    join
    check("bp_w49_stall", 512'(waits >= 9 && waits <= 11), 512'(1));
    bus_read(2'd0, rd);
    check("bp_status_after", 512'(rd), 512'(32'h0000_0202));
    check("bp_popped_one", 512'(got_q.size()), 512'(1));
    wr(2'd3, 32'd0);
    model_msg(msg);
    ready_force = 1'b1;
    drain_check("bp");

    // Soft clear flushes a queued block and the partial accumulator
    ready_force = 1'b0;
    for (int i = 0; i < 19; i++) wr(2'd0, $urandom);
    wr(2'd1, 32'd1);
    bus_read(2'd0, rd);
    check("clr_status", 512'(rd), 512'(0));
    bus_read(2'd2, rd);
    check("clr_len", 512'(rd), 512'(0));
    send_msg(abc);
    ready_force = 1'b1;
    drain_check("clr_abc");

    // Reset in the middle of zero fill
    ready_force = 1'b0;
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'h01);
    for (int i = 0; i < 14; i++) wr(2'd0, 32'h0101_0101);
    wr(2'd3, 32'd0);
    repeat (4) @(negedge clk_clk);
    check("midrst_pre_valid", 512'(blk_valid), 512'(1));
    reset_reset = 1'b1;
    #1;
    check("midrst_valid", 512'(blk_valid), 512'(0));
    check("midrst_readdata", 512'(avs_readdata), 512'(0));
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b0;
    check("midrst_nopop", 512'(got_q.size()), 512'(0));
    send_msg(abc);
    ready_force = 1'b1;
    drain_check("midrst_abc");
    check("midrst_w0", 512'(last_got.data[511:480]), 512'(32'h6162_6380));

    // Random lengths with random core backpressure
    rand_ready = 1'b1;
    for (int m = 0; m < 10; m++) begin
      msg.delete();
      len = $urandom_range(0, 140);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      send_msg(msg);
    end
    drain_check("rand");
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
